// File: rtl/fixed_lerp_sat_if.sv
// Streaming bus for the lerp block: operand side (a, b, t) and result side (y, sat).
// Latency: none; this file only bundles wires.
// Backpressure: valid/ready on both sides; the slave modport is the lerp block.
//
// Signals:
//   in_valid/in_ready    input handshake
//   in_a, in_b           signed start/end samples
//   in_t                 unsigned weight, TIW integer + FW fraction bits
//   out_valid/out_ready  output handshake
//   out_y                signed result
//   out_sat              out_y was clamped
interface fixed_lerp_sat_if #(
    parameter int DW  = 12,
    parameter int FW  = 8,
    parameter int TIW = 1
);
    logic                  in_valid;
    logic                  in_ready;
    logic signed [DW-1:0]  in_a;
    logic signed [DW-1:0]  in_b;
    logic [TIW+FW-1:0]     in_t;
    logic                  out_valid;
    logic                  out_ready;
    logic signed [DW-1:0]  out_y;
    logic                  out_sat;

    // Producer of operands / consumer of results.
    modport master (
        output in_valid, in_a, in_b, in_t, out_ready,
        input  in_ready, out_valid, out_y, out_sat
    );

    // The interpolator itself.
    modport slave (
        input  in_valid, in_a, in_b, in_t, out_ready,
        output in_ready, out_valid, out_y, out_sat
    );
endinterface

// File: rtl/fixed_lerp_sat.sv
// Signed fixed-point lerp/extrapolate y = a + (b - a) * t, rounded and clamped to DW bits.
// Latency: 3 register stages (S1 diff, S2 multiply, S3 round/clamp); 1 sample/cycle.
// Backpressure: one global enable, en = !out_valid || out_ready; in_ready = en; all stages hold when en=0.
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset (drops all in-flight samples)
//   clr         synchronous clear of sat_cnt, wins over a same-cycle increment
//   bus         fixed_lerp_sat_if slave: in_* operands, out_* results
//   sat_cnt     saturating count of transferred results with out_sat=1
module fixed_lerp_sat #(
    parameter int DW    = 12,
    parameter int FW    = 8,
    parameter int TIW   = 1,
    parameter int ROUND = 1,
    parameter int CW    = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    fixed_lerp_sat_if.slave bus,
    output logic [CW-1:0]   sat_cnt
);
    localparam int TW = TIW + FW;      // width of t
    localparam int PW = DW + TW + 2;   // product width
    localparam int SW = DW + TW + 3;   // sum width, one guard bit over the product

    localparam int                     RND_I    = (ROUND != 0) ? (1 << (FW - 1)) : 0;
    localparam logic signed [SW-1:0]   RND      = SW'(RND_I);
    localparam logic signed [SW-1:0]   Y_MAX    = SW'((1 << (DW - 1)) - 1);
    localparam logic signed [SW-1:0]   Y_MIN    = ~Y_MAX;
    localparam logic [CW-1:0]          CNT_MAX  = '1;

    // Single enable for the whole pipe: an empty output stage never blocks.
    logic en;

    // S1: difference, start sample, weight
    logic                  v1;
    logic signed [DW:0]    d1;
    logic signed [DW-1:0]  a1;
    logic [TW-1:0]         t1;

    // S2: product, start sample
    logic                  v2;
    logic signed [PW-1:0]  p2;
    logic signed [DW-1:0]  a2;

    // S3: registered outputs
    logic                  v3;
    logic signed [DW-1:0]  y3;
    logic                  sat3;

    // Combinational next-state for S2 and S3
    logic signed [PW-1:0]  d_ext;
    logic signed [PW-1:0]  t_ext;
    logic signed [PW-1:0]  p_nxt;
    logic signed [SW-1:0]  a_ext;
    logic signed [SW-1:0]  p_ext;
    logic signed [SW-1:0]  s;
    logic signed [SW-1:0]  q;
    logic signed [DW-1:0]  y_nxt;
    logic                  sat_nxt;

    assign en            = !v3 || bus.out_ready;
    assign bus.in_ready  = en;
    assign bus.out_valid = v3;
    assign bus.out_y     = y3;
    assign bus.out_sat   = sat3;

    always_comb begin
        // t is zero-extended so a weight with its top bit set stays positive.
        d_ext = {{(PW-DW-1){d1[DW]}}, d1};
        t_ext = {{(PW-TW){1'b0}}, t1};
        p_nxt = d_ext * t_ext;
    end

    always_comb begin
        a_ext = {{(SW-DW){a2[DW-1]}}, a2};
        p_ext = {p2[PW-1], p2};
        s     = (a_ext <<< FW) + p_ext + RND;
        q     = s >>> FW;
        y_nxt   = q[DW-1:0];
        sat_nxt = 1'b0;
        if (q > Y_MAX) begin
            y_nxt   = Y_MAX[DW-1:0];
            sat_nxt = 1'b1;
        end else if (q < Y_MIN) begin
            y_nxt   = Y_MIN[DW-1:0];
            sat_nxt = 1'b1;
        end
    end

    // Data registers advance with en even for bubbles; only the valid bits matter then.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1   <= 1'b0;
            d1   <= '0;
            a1   <= '0;
            t1   <= '0;
            v2   <= 1'b0;
            p2   <= '0;
            a2   <= '0;
            v3   <= 1'b0;
            y3   <= '0;
            sat3 <= 1'b0;
        end else if (en) begin
            v1   <= bus.in_valid;
            d1   <= {bus.in_b[DW-1], bus.in_b} - {bus.in_a[DW-1], bus.in_a};
            a1   <= bus.in_a;
            t1   <= bus.in_t;
            v2   <= v1;
            p2   <= p_nxt;
            a2   <= a1;
            v3   <= v2;
            y3   <= y_nxt;
            sat3 <= sat_nxt;
        end
    end

    // Counts only results that actually leave the block; sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_cnt <= '0;
        end else if (clr) begin
            sat_cnt <= '0;
        end else if (v3 && bus.out_ready && sat3 && (sat_cnt != CNT_MAX)) begin
            sat_cnt <= sat_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_fixed_lerp_sat.sv
// Directed bench for fixed_lerp_sat: default build, a floor-rounding build and a 2-bit counter build
// share identical stimulus; results compared against hand-computed values.
// Latency/backpressure are checked cycle by cycle from the bench side.
module tb_fixed_lerp_sat;
    logic              clk = 1'b0;
    logic              rst;
    logic              clr;
    logic              in_valid;
    logic              out_ready;
    logic signed [11:0] in_a;
    logic signed [11:0] in_b;
    logic [8:0]        in_t;
    logic [15:0]       cnt;
    logic [15:0]       cnt_r0;
    logic [1:0]        cnt_c2;

    int n_assert = 0;
    int n_fail   = 0;

    fixed_lerp_sat_if #(.DW(12), .FW(8), .TIW(1)) bi  ();
    fixed_lerp_sat_if #(.DW(12), .FW(8), .TIW(1)) br0 ();
    fixed_lerp_sat_if #(.DW(12), .FW(8), .TIW(1)) bc2 ();

    assign bi.in_valid  = in_valid;
    assign bi.in_a      = in_a;
    assign bi.in_b      = in_b;
    assign bi.in_t      = in_t;
    assign bi.out_ready = out_ready;
    assign br0.in_valid  = in_valid;
    assign br0.in_a      = in_a;
    assign br0.in_b      = in_b;
    assign br0.in_t      = in_t;
    assign br0.out_ready = out_ready;
    assign bc2.in_valid  = in_valid;
    assign bc2.in_a      = in_a;
    assign bc2.in_b      = in_b;
    assign bc2.in_t      = in_t;
    assign bc2.out_ready = out_ready;

    fixed_lerp_sat #(.DW(12), .FW(8), .TIW(1), .ROUND(1), .CW(16)) dut (
        .clk(clk), .rst(rst), .clr(clr), .bus(bi), .sat_cnt(cnt)
    );
    fixed_lerp_sat #(.DW(12), .FW(8), .TIW(1), .ROUND(0), .CW(16)) dut_r0 (
        .clk(clk), .rst(rst), .clr(clr), .bus(br0), .sat_cnt(cnt_r0)
    );
    fixed_lerp_sat #(.DW(12), .FW(8), .TIW(1), .ROUND(1), .CW(2)) dut_c2 (
        .clk(clk), .rst(rst), .clr(clr), .bus(bc2), .sat_cnt(cnt_c2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Present one sample for one cycle, wait (bounded) for the result, check latency and values.
    // Returns at the negedge where the result is visible; it transfers on the next posedge.
    task automatic send(input string tag, input int a, input int b, input int t,
                        input int ey, input int esat, input int ey0);
        int lat;
        @(negedge clk);
        in_valid = 1'b1;
        in_a = 12'(a);
        in_b = 12'(b);
        in_t = 9'(t);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!bi.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, 3);
        chk({tag, "_y"}, bi.out_y, ey);
        chk({tag, "_sat"}, {31'd0, bi.out_sat}, esat);
        chk({tag, "_y_floor"}, br0.out_y, ey0);
    endtask

    initial begin
        int idx;
        int rcv;

        rst = 1'b1;
        clr = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_a = '0;
        in_b = '0;
        in_t = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", {31'd0, bi.out_valid}, 0);
        chk("rst_out_y", bi.out_y, 0);
        chk("rst_out_sat", {31'd0, bi.out_sat}, 0);
        chk("rst_sat_cnt", {16'd0, cnt}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", {31'd0, bi.in_ready}, 1);

        // Latency and midpoint
        send("mid", 100, 200, 'h080, 150, 0, 150);
        @(negedge clk);
        chk("mid_valid_drops", {31'd0, bi.out_valid}, 0);

        // Interpolation, sign and rounding mode
        send("neg", -100, 100, 'h040, -50, 0, -50);
        send("half_up", 0, 1, 'h080, 1, 0, 0);
        send("half_dn", 0, -1, 'h080, 0, 0, -1);

        // Saturation
        send("sat_hi", 0, 2000, 'h1C0, 2047, 1, 2047);
        send("sat_lo", 0, -2000, 'h1C0, -2048, 1, -2048);
        send("sat_ext", 2047, -2048, 'h1FF, -2048, 1, -2048);
        @(negedge clk);
        chk("sat_cnt_3", {16'd0, cnt}, 3);

        // Backpressure: 8 samples, out_ready low for cycles 4..8
        idx = 0;
        rcv = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 4 && cyc < 9);
            in_valid = (idx < 8);
            in_a = 12'(idx * 10);
            in_b = 12'(idx * 10 + 100);
            in_t = 9'h080;
            #1;
            if (!out_ready) begin
                chk("bp_in_ready", {31'd0, bi.in_ready}, 0);
                chk("bp_out_valid", {31'd0, bi.out_valid}, 1);
                chk("bp_hold_y", bi.out_y, rcv * 10 + 50);
            end else if (bi.out_valid) begin
                chk("stream_y", bi.out_y, rcv * 10 + 50);
                rcv++;
            end
            if (in_valid && bi.in_ready) idx++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stream_sent", idx, 8);
        chk("stream_rcvd", rcv, 8);

        // Counter saturation and clear priority
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_cnt", {16'd0, cnt}, 0);
        chk("clr_cnt_c2", {30'd0, cnt_c2}, 0);
        for (int i = 0; i < 5; i++) send("cnt_sat", 0, 2000, 'h1C0, 2047, 1, 2047);
        @(negedge clk);
        chk("cnt_wide_5", {16'd0, cnt}, 5);
        chk("cnt_c2_stuck", {30'd0, cnt_c2}, 3);
        send("clr_sat", 0, -2000, 'h1C0, -2048, 1, -2048);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_wins_cnt", {16'd0, cnt}, 0);
        chk("clr_wins_c2", {30'd0, cnt_c2}, 0);

        // Reset with three samples in flight
        @(negedge clk);
        in_valid = 1'b1;
        in_a = 12'sd10;
        in_b = 12'sd20;
        in_t = 9'h000;
        @(negedge clk);
        in_a = 12'sd30;
        @(negedge clk);
        in_a = 12'sd50;
        @(negedge clk);
        in_valid = 1'b0;
        chk("flight_out_valid", {31'd0, bi.out_valid}, 1);
        chk("flight_out_y", bi.out_y, 10);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", {31'd0, bi.out_valid}, 0);
        chk("arst_out_y", bi.out_y, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_no_stale", {31'd0, bi.out_valid}, 0);
        end
        send("post_rst", 100, 200, 'h080, 150, 0, 150);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
